// File: rtl/clock_ctrl_pkg.sv
// Shared mode/field encodings for the clock UI, timekeeper, alarm and display blocks.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_e;

    localparam logic [2:0] FIELD_SEC  = 3'b001;
    localparam logic [2:0] FIELD_MIN  = 3'b010;
    localparam logic [2:0] FIELD_HOUR = 3'b100;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:       return MODE_SET_TIME;
            MODE_SET_TIME:  return MODE_SET_ALARM;
            MODE_SET_ALARM: return MODE_STOPWATCH;
            default:        return MODE_RUN;
        endcase
    endfunction

    // hour -> min -> sec -> hour
    function automatic logic [2:0] next_field(input logic [2:0] f);
        return {f[0], f[2:1]};
    endfunction

    function automatic logic is_set_mode(input mode_e m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_repeat.sv
// Press detection and hold-to-repeat pulse generation for one push-button.
module btn_repeat #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic repeat_en_i,
    input  logic clear_i,
    output logic level_o,
    output logic press_o,
    output logic fire_o
);

    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_DLY    = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] CNT_TOP    = CW'(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY + 1);

    logic          lvl_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held, rpt_hit;

    assign level_o = lvl_q;
    assign press_o = lvl_q & ~prev_q;
    assign held    = lvl_q & prev_q;
    assign rpt_hit = repeat_en_i & held & ((cnt_q == CNT_DLY) || (cnt_q == CNT_TOP));
    assign fire_o  = ~clear_i & (press_o | rpt_hit);

    // A zero count while held means repeat is disarmed until the next fresh press.
    always_comb begin
        cnt_d = '0;
        if (clear_i || !lvl_q || !repeat_en_i)
            cnt_d = '0;
        else if (press_o)
            cnt_d = CNT_ONE;
        else if (cnt_q == CNT_TOP)
            cnt_d = CNT_RELOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q  <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            lvl_q  <= btn_i;
            prev_q <= lvl_q;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button sequencer: mode FSM, field selection, alarm dismiss and command pulse decode.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       alarm_active,
    output logic [1:0] mode,
    output logic [2:0] field,
    output logic [2:0] time_inc,
    output logic [2:0] time_dec,
    output logic [2:0] alarm_inc,
    output logic [2:0] alarm_dec,
    output logic       time_hold,
    output logic       alarm_en,
    output logic       dis_alarm,
    output logic       sw_start_stop,
    output logic       sw_clear
);

    mode_e      mode_q, mode_nxt;
    logic [2:0] field_q, time_inc_q, time_dec_q, alarm_inc_q, alarm_dec_q;
    logic       time_hold_q, alarm_en_q, dis_alarm_q, sw_ss_q, sw_clr_q;
    logic       mode_lvl_q, mode_prev_q, sel_lvl_q, sel_prev_q;

    logic p_mode, p_sel, p_up, p_dn, fire_up, fire_dn, lvl_up, lvl_dn;
    logic dismiss, rpt_clear, rpt_en;

    assign p_mode    = mode_lvl_q & ~mode_prev_q;
    assign p_sel     = sel_lvl_q & ~sel_prev_q;
    assign dismiss   = alarm_active & (p_mode | p_sel | p_up | p_dn);
    assign rpt_clear = dismiss | p_mode | (lvl_up & lvl_dn);
    assign rpt_en    = is_set_mode(mode_q);
    assign mode_nxt  = next_mode(mode_q);

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .repeat_en_i(rpt_en), .clear_i(rpt_clear),
        .level_o(lvl_up), .press_o(p_up), .fire_o(fire_up)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
        .clk(clk), .rst(rst), .btn_i(btn_down), .repeat_en_i(rpt_en), .clear_i(rpt_clear),
        .level_o(lvl_dn), .press_o(p_dn), .fire_o(fire_dn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_RUN;
            field_q     <= FIELD_HOUR;
            time_inc_q  <= '0;
            time_dec_q  <= '0;
            alarm_inc_q <= '0;
            alarm_dec_q <= '0;
            time_hold_q <= 1'b0;
            alarm_en_q  <= 1'b0;
            dis_alarm_q <= 1'b0;
            sw_ss_q     <= 1'b0;
            sw_clr_q    <= 1'b0;
            mode_lvl_q  <= 1'b1;
            mode_prev_q <= 1'b1;
            sel_lvl_q   <= 1'b1;
            sel_prev_q  <= 1'b1;
        end else begin
            mode_lvl_q  <= btn_mode;
            mode_prev_q <= mode_lvl_q;
            sel_lvl_q   <= btn_sel;
            sel_prev_q  <= sel_lvl_q;
            time_inc_q  <= '0;
            time_dec_q  <= '0;
            alarm_inc_q <= '0;
            alarm_dec_q <= '0;
            sw_ss_q     <= 1'b0;
            sw_clr_q    <= 1'b0;
            dis_alarm_q <= dismiss;
            // A ringing alarm swallows every press; a mode press swallows the rest.
            if (!dismiss) begin
                if (p_mode) begin
                    mode_q      <= mode_nxt;
                    time_hold_q <= (mode_nxt == MODE_SET_TIME);
                    if (is_set_mode(mode_nxt))
                        field_q <= FIELD_HOUR;
                end else begin
                    case (mode_q)
                        MODE_RUN: begin
                            if (p_sel) alarm_en_q <= ~alarm_en_q;
                        end
                        MODE_SET_TIME: begin
                            if (p_sel)   field_q    <= next_field(field_q);
                            if (fire_up) time_inc_q <= field_q;
                            if (fire_dn) time_dec_q <= field_q;
                        end
                        MODE_SET_ALARM: begin
                            if (p_sel)   field_q     <= next_field(field_q);
                            if (fire_up) alarm_inc_q <= field_q;
                            if (fire_dn) alarm_dec_q <= field_q;
                        end
                        MODE_STOPWATCH: begin
                            sw_ss_q  <= fire_up;
                            sw_clr_q <= fire_dn;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mode          = mode_q;
    assign field         = field_q;
    assign time_inc      = time_inc_q;
    assign time_dec      = time_dec_q;
    assign alarm_inc     = alarm_inc_q;
    assign alarm_dec     = alarm_dec_q;
    assign time_hold     = time_hold_q;
    assign alarm_en      = alarm_en_q;
    assign dis_alarm     = dis_alarm_q;
    assign sw_start_stop = sw_ss_q;
    assign sw_clear      = sw_clr_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with short repeat timing (delay 8, period 3).
module tb_clock_mode_ctrl;

    localparam logic [2:0] H = 3'b100;
    localparam logic [2:0] M = 3'b010;
    localparam logic [2:0] S = 3'b001;
    localparam logic [2:0] Z = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       alarm_active = 1'b0;
    logic [1:0] mode;
    logic [2:0] field, time_inc, time_dec, alarm_inc, alarm_dec;
    logic       time_hold, alarm_en, dis_alarm, sw_start_stop, sw_clear;
    logic [21:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    clock_mode_ctrl #(.REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
        .alarm_active(alarm_active),
        .mode(mode), .field(field),
        .time_inc(time_inc), .time_dec(time_dec),
        .alarm_inc(alarm_inc), .alarm_dec(alarm_dec),
        .time_hold(time_hold), .alarm_en(alarm_en), .dis_alarm(dis_alarm),
        .sw_start_stop(sw_start_stop), .sw_clear(sw_clear)
    );

    always #5 clk = ~clk;

    assign obs = {mode, field, time_inc, time_dec, alarm_inc, alarm_dec,
                  time_hold, alarm_en, dis_alarm, sw_start_stop, sw_clear};

    typedef struct {
        string       name;
        logic [4:0]  in;   // {mode, sel, up, down, alarm_active}
        logic [21:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [21:0] pk(input logic [1:0] md, input logic [2:0] f,
                                       input logic [2:0] ti, input logic [2:0] td,
                                       input logic [2:0] ai, input logic [2:0] ad,
                                       input logic h, input logic en, input logic dis,
                                       input logic ss, input logic clr);
        return {md, f, ti, td, ai, ad, h, en, dis, ss, clr};
    endfunction

    function automatic vec_t mk(input string n, input logic [4:0] in, input logic [21:0] e);
        vec_t v;
        v.name = n;
        v.in   = in;
        v.exp  = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [21:0] got, input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One-cycle tap, then one idle cycle so the registered response is visible.
    task automatic tap(input logic [4:0] in);
        {btn_mode, btn_sel, btn_up, btn_down, alarm_active} = in;
        @(negedge clk);
        {btn_mode, btn_sel, btn_up, btn_down} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [21:0] rst_exp;
    logic [2:0]  e3;

    initial begin
        rst_exp = pk(2'd0, H, Z, Z, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", obs, rst_exp);

        vq.push_back(mk("idle",         5'b00000, pk(0, H, Z, Z, Z, Z, 0, 0, 0, 0, 0)));
        vq.push_back(mk("run_sel_on",   5'b01000, pk(0, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("run_sel_off",  5'b01000, pk(0, H, Z, Z, Z, Z, 0, 0, 0, 0, 0)));
        vq.push_back(mk("run_sel_on2",  5'b01000, pk(0, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("run_up_ign",   5'b00100, pk(0, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("to_set_time",  5'b10000, pk(1, H, Z, Z, Z, Z, 1, 1, 0, 0, 0)));
        vq.push_back(mk("st_up_hour",   5'b00100, pk(1, H, H, Z, Z, Z, 1, 1, 0, 0, 0)));
        vq.push_back(mk("st_sel_min",   5'b01000, pk(1, M, Z, Z, Z, Z, 1, 1, 0, 0, 0)));
        vq.push_back(mk("st_down_min",  5'b00010, pk(1, M, Z, M, Z, Z, 1, 1, 0, 0, 0)));
        vq.push_back(mk("to_set_alarm", 5'b10000, pk(2, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sa_sel_min",   5'b01000, pk(2, M, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sa_sel_sec",   5'b01000, pk(2, S, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sa_down_sec",  5'b00010, pk(2, S, Z, Z, Z, S, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sa_up_sec",    5'b00100, pk(2, S, Z, Z, S, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sa_sel_wrap",  5'b01000, pk(2, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("to_stopwatch", 5'b10000, pk(3, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("sw_up_start",  5'b00100, pk(3, H, Z, Z, Z, Z, 0, 1, 0, 1, 0)));
        vq.push_back(mk("sw_down_clr",  5'b00010, pk(3, H, Z, Z, Z, Z, 0, 1, 0, 0, 1)));
        vq.push_back(mk("sw_sel_ign",   5'b01000, pk(3, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("to_run",       5'b10000, pk(0, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("mode_up_same", 5'b10100, pk(1, H, Z, Z, Z, Z, 1, 1, 0, 0, 0)));
        vq.push_back(mk("dismiss_up",   5'b00101, pk(1, H, Z, Z, Z, Z, 1, 1, 1, 0, 0)));
        vq.push_back(mk("dismiss_mode", 5'b10001, pk(1, H, Z, Z, Z, Z, 1, 1, 1, 0, 0)));
        vq.push_back(mk("dismiss_sel",  5'b01001, pk(1, H, Z, Z, Z, Z, 1, 1, 1, 0, 0)));
        vq.push_back(mk("mode_dn_same", 5'b10010, pk(2, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("up_dn_tap",    5'b00110, pk(2, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));
        vq.push_back(mk("mode_sel_sa",  5'b11000, pk(3, H, Z, Z, Z, Z, 0, 1, 0, 0, 0)));

        foreach (vq[i]) begin
            tap(vq[i].in);
            chk(vq[i].name, obs, vq[i].exp);
        end
        alarm_active = 1'b0;

        // Auto-repeat: held 20 cycles from edge N
        do_reset();
        tap(5'b10000);
        chk("rpt_setup", obs, pk(1, H, Z, Z, Z, Z, 1, 0, 0, 0, 0));
        btn_up = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            e3 = (i == 1 || i == 9 || i == 12 || i == 15 || i == 18) ? H : Z;
            chk($sformatf("rpt_%0d", i), obs, pk(1, H, e3, Z, Z, Z, 1, 0, 0, 0, 0));
            if (i == 19) btn_up = 1'b0;
        end

        // Dismiss consumes the press and disarms repeat for the whole hold
        alarm_active = 1'b1;
        btn_up = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk($sformatf("dis_hold_%0d", i), obs,
                pk(1, H, Z, Z, Z, Z, 1, 0, (i == 1), 0, 0));
            if (i == 19) btn_up = 1'b0;
        end
        alarm_active = 1'b0;
        @(negedge clk);

        // Up and down held together
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("both_%0d", i), obs, pk(1, H, Z, Z, Z, Z, 1, 0, 0, 0, 0));
            if (i == 12) begin
                btn_up = 1'b0;
                btn_down = 1'b0;
            end
        end

        // Down briefly joins a held up: up must not resume repeating
        btn_up = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk($sformatf("join_%0d", i), obs,
                pk(1, H, (i == 1) ? H : Z, Z, Z, Z, 1, 0, 0, 0, 0));
            if (i == 3) btn_down = 1'b1;
            if (i == 5) btn_down = 1'b0;
            if (i == 18) btn_up = 1'b0;
        end

        // Reset mid-hold with up and sel held across reset release
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        btn_sel = 1'b1;
        #1;
        chk("rst_async", obs, rst_exp);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_held_%0d", i), obs, rst_exp);
        end
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        @(negedge clk);
        chk("rst_mode_in", obs, pk(1, H, Z, Z, Z, Z, 1, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rst_norpt_%0d", i), obs, pk(1, H, Z, Z, Z, Z, 1, 0, 0, 0, 0));
        end
        btn_up = 1'b0;
        btn_sel = 1'b0;
        repeat (2) @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_repress", obs, pk(1, H, H, Z, Z, Z, 1, 0, 0, 0, 0));
        btn_up = 1'b0;
        @(negedge clk);
        chk("rst_pulse_end", obs, pk(1, H, Z, Z, Z, Z, 1, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

User-interface sequencer for the multi-mode clock. Converts four debounced push-buttons into the single-cycle increment/decrement pulses, mode and field selection, alarm enable/dismiss and stopwatch commands consumed by the timekeeping, alarm and stopwatch blocks. Sits between the button debouncers and those blocks. Owns the only mode state machine in the design.

## Interface
- REPEAT_DELAY, 500: cycles a held up/down button must stay high before auto-repeat starts (≥2)
- REPEAT_PERIOD, 100: cycles between auto-repeat pulses (≥1)
- clk  in  1  clock; reset rst, asynchronous, active-high
- rst  in  1  asynchronous active-high reset
- btn_mode, btn_sel, btn_up, btn_down  in  1 each  debounced, clk-synchronous button levels, high = pressed
- alarm_active  in  1  alarm block is currently ringing
- mode  out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 STOPWATCH
- field  out  3  one-hot edit field: [0] sec, [1] min, [2] hour
- time_inc, time_dec  out  3  one-cycle pulse on the field bit, to timekeeper
- alarm_inc, alarm_dec  out  3  one-cycle pulse on the field bit, to alarm setpoint
- time_hold  out  1  high while mode = SET_TIME; freezes timekeeper counting
- alarm_en  out  1  alarm arm level
- dis_alarm  out  1  one-cycle dismiss pulse
- sw_start_stop, sw_clear  out  1  one-cycle stopwatch command pulses

## Operation
- Press = rising edge of a button level (previous-sample register low, current high).
- Dismiss priority: while alarm_active = 1, any press on any button produces dis_alarm and is consumed. No other action that cycle, no repeat from that press.
- Mode FSM: btn_mode press advances RUN→SET_TIME→SET_ALARM→STOPWATCH→RUN. Entering SET_TIME or SET_ALARM loads field = 3'b100 (hour).
- btn_mode press in the same cycle as an up/down/sel press: mode change wins; the other presses are discarded and the repeat state is cleared.
- RUN: btn_sel press toggles alarm_en; up/down ignored.
- SET_TIME / SET_ALARM:
  - btn_sel rotates field hour→min→sec→hour.
  - up/down generate time_* or alarm_* pulses equal to field.
- STOPWATCH: btn_up press → sw_start_stop; btn_down press → sw_clear; no auto-repeat; sel ignored.
- Auto-repeat (SET modes only):
  - Pulse on the press.
  - While the button is held, a further pulse when the hold counter reaches REPEAT_DELAY, then one every REPEAT_PERIOD cycles.
  - The counter saturates logic and never wraps to a spurious early pulse.
  - Release clears the counter.
- up and down both high: neither pulses; both repeat counters cleared. Operation resumes only on a fresh press.
- field change during a hold: subsequent repeat pulses use the new field.
- At most one of time_inc/time_dec/alarm_inc/alarm_dec is nonzero in any cycle, and it is one-hot.

## Timing
- All outputs registered.
- Button sampled high at edge N, low at N-1 → pulse or state change visible after edge N+1 (1-cycle latency). Pulses last exactly 1 cycle.
- Repeat: press at N → pulse at N+1. Held continuously → pulses at N+1+REPEAT_DELAY, then +REPEAT_PERIOD each.
- Hold counter width $clog2(REPEAT_DELAY+REPEAT_PERIOD+1).
- Reset values: mode RUN, field 3'b100, alarm_en 0, time_hold 0, all pulse outputs 0, hold counters 0.
- Previous-sample registers reset to 1, so a button held through reset release does not fire until released and pressed again.
- Reset mid-hold or mid-mode aborts everything, with no pulse in the cycle rst deasserts.

## Structure
- Package clock_ctrl_pkg:
  - mode encodings (MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM, MODE_STOPWATCH)
  - field one-hot constants (FIELD_SEC, FIELD_MIN, FIELD_HOUR)
  - shared with timekeeper, alarm and display blocks.
- Sub-module btn_repeat: edge detect, hold counter, repeat pulse generation, and repeat_en and clear inputs. Instanced for btn_up and btn_down.
- Mode FSM, field rotation, dismiss logic and output decode stay in clock_mode_ctrl.

## Test plan
Benches run with REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Mode rotation: reset; 4 single-cycle btn_mode presses → mode 1,2,3,0; field = 3'b100 on entering modes 1 and 2; time_hold high only in mode 1.
- Auto-repeat: SET_TIME, field hour; hold btn_up 20 cycles from edge N → time_inc = 3'b100 at N+1, N+9, N+12, N+15, N+18, none after release.
- Field and alarm edit: SET_ALARM; sel, sel, tap down → field 3'b001, single alarm_dec = 3'b001, time_* stays 0.
- Dismiss: alarm_active = 1 in SET_TIME; press btn_up → dis_alarm one cycle, no time_inc, mode unchanged; hold 20 cycles → no repeats.
- Conflicts: btn_mode and btn_up pressed same cycle in SET_TIME → mode 2, no pulse. Up and down held together → no pulses.
- Reset: assert rst mid-hold with btn_up still high, release rst → all outputs at reset values, no pulse until btn_up drops and rises again.
